queue_counter: RTL

Upstream stage of the queue display path. Turns two raw photo-sensor inputs (rear = person joins, front = person leaves) into a saturating occupancy count `Pcount` that drives the single-digit seven-segment decoder directly. Also produces full/empty flags, a dropped-event error pulse and a registered estimated wait time. Sensor inputs are asynchronous. All outputs are registered in the `clk` domain.

---
 rtl/queue_pkg.sv | 22 ++
 rtl/qc_debounce.sv | 144 ++++++++++++++
 rtl/queue_counter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/queue_pkg.sv
// Shared types and constants for the queue occupancy counter.
// The debouncer state type is only used when QUEUE_COUNTER_DEBOUNCE_EN is defined.
package queue_pkg;

    // Debouncer FSM states
    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } deb_state_t;

    // Pcount width: one BCD digit
    localparam int CNT_W         = 4;
    // Estimated wait-time width
    localparam int WT_W          = 8;
    // Width of the debounce stability counter (DEB_CYCLES up to 255)
    localparam int DEB_CNT_W     = 8;
    // Default queue capacity
    localparam int MAX_COUNT_DEF = 7;

endpackage

// File: rtl/qc_debounce.sv
// One sensor channel: 2-flop synchronizer, optional debounce FSM and
// rising-edge detector.
// Build option: QUEUE_COUNTER_DEBOUNCE_EN selects the debounce FSM; when it
// is undefined the second synchronizer stage is the level directly.
//
// rise_pulse is taken from the next-state level, so the downstream count
// register updates on the same edge at which the level register goes high.
// That gives the count change on edge DEB_CYCLES+2 (debounced) or edge 2
// (undebounced), counting from the first edge that samples the raw input high.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LOW      | level 0, waiting for a synchronized 1
// RISE_CHK | level 0, counting consecutive 1 samples up to DEB_CYCLES
// HIGH     | level 1, waiting for a synchronized 0
// FALL_CHK | level 1, counting consecutive 0 samples up to DEB_CYCLES
module qc_debounce
    import queue_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sensor,
    output logic level,
    output logic rise_pulse
);

    logic r_sync1;
    logic r_sync2;

    // Two-flop synchronizer for the asynchronous sensor input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_sensor;
            r_sync2 <= r_sync1;
        end
    end

`ifdef QUEUE_COUNTER_DEBOUNCE_EN
    localparam logic [DEB_CNT_W-1:0] DEB_C = DEB_CYCLES[DEB_CNT_W-1:0];

    deb_state_t           r_state;
    deb_state_t           w_state_nxt;
    logic [DEB_CNT_W-1:0] r_cnt;
    logic [DEB_CNT_W-1:0] w_cnt_nxt;
    logic [DEB_CNT_W-1:0] w_cnt_inc;
    logic                 r_level;
    logic                 w_level_nxt;

    assign w_cnt_inc = r_cnt + DEB_CNT_W'(1);

    // Debounce state, stability counter and level registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
        end
    end

    // Next-state logic: a level change needs DEB_CYCLES consecutive samples
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        case (r_state)
            LOW: begin
                if (r_sync2) begin
                    if (DEB_CYCLES == 1) begin
                        w_state_nxt = HIGH;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b1;
                    end else begin
                        w_state_nxt = RISE_CHK;
                        w_cnt_nxt   = DEB_CNT_W'(1);
                    end
                end
            end
            RISE_CHK: begin
                if (!r_sync2) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == DEB_C) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            HIGH: begin
                if (!r_sync2) begin
                    if (DEB_CYCLES == 1) begin
                        w_state_nxt = LOW;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b0;
                    end else begin
                        w_state_nxt = FALL_CHK;
                        w_cnt_nxt   = DEB_CNT_W'(1);
                    end
                end
            end
            FALL_CHK: begin
                if (r_sync2) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_inc == DEB_C) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = '0;
                    w_level_nxt = 1'b0;
                end else begin
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = LOW;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign level      = r_level;
    assign rise_pulse = w_level_nxt & ~r_level;
`else
    // Undebounced: the second synchronizer stage is the level
    assign level      = r_sync2;
    assign rise_pulse = r_sync1 & ~r_sync2;
`endif

    // Reject a debounce length the stability counter cannot hold
    if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb_cycles
        $error("qc_debounce: DEB_CYCLES must be in 1..255");
    end

endmodule

// File: rtl/queue_counter.sv
// Queue occupancy counter: turns rear (entry) and front (exit) photo-sensor
// events into a saturating count with full/empty flags, a dropped-event pulse
// and an estimated wait time. All outputs are registered from the next count.
// Build option: QUEUE_COUNTER_DEBOUNCE_EN enables the per-channel debouncers.
module queue_counter
    import queue_pkg::*;
#(
    parameter int MAX_COUNT  = MAX_COUNT_DEF,
    parameter int DEB_CYCLES = 4,
    parameter int SERVICE_T  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            entry_sensor,
    input  logic            exit_sensor,
    output logic [CNT_W-1:0] Pcount,
    output logic            full,
    output logic            empty,
    output logic [WT_W-1:0] wtime,
    output logic            drop_err
);

    localparam logic [CNT_W-1:0] MAX_C = MAX_COUNT[CNT_W-1:0];
    localparam logic [WT_W-1:0]  SVC_C = SERVICE_T[WT_W-1:0];

    logic             w_ev_in;
    logic             w_ev_out;
    // Channel levels are not needed by the count logic; kept for probing
    logic [1:0]       w_unused_level;

    logic [CNT_W-1:0] r_pcount;
    logic             r_full;
    logic             r_empty;
    logic [WT_W-1:0]  r_wtime;
    logic             r_drop_err;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_drop_nxt;
    logic [WT_W-1:0]  w_wtime_nxt;

    qc_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_entry (
        .clk        (clk),
        .rst        (rst),
        .i_sensor   (entry_sensor),
        .level      (w_unused_level[0]),
        .rise_pulse (w_ev_in)
    );

    qc_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_exit (
        .clk        (clk),
        .rst        (rst),
        .i_sensor   (exit_sensor),
        .level      (w_unused_level[1]),
        .rise_pulse (w_ev_out)
    );

    // Next count: saturate at 0 and MAX_COUNT; simultaneous events cancel
    always_comb begin
        w_cnt_nxt  = r_pcount;
        w_drop_nxt = 1'b0;
        case ({w_ev_in, w_ev_out})
            2'b10: begin
                if (r_pcount == MAX_C) begin
                    w_drop_nxt = 1'b1;
                end else begin
                    w_cnt_nxt  = r_pcount + CNT_W'(1);
                end
            end
            2'b01: begin
                if (r_pcount == '0) begin
                    w_drop_nxt = 1'b1;
                end else begin
                    w_cnt_nxt  = r_pcount - CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nxt  = r_pcount;
                w_drop_nxt = 1'b0;
            end
        endcase
    end

    // Wait estimate from the next count: people ahead times service time
    always_comb begin
        w_wtime_nxt = '0;
        if (w_cnt_nxt != '0) begin
            w_wtime_nxt = SVC_C * ({{(WT_W-CNT_W){1'b0}}, w_cnt_nxt} - WT_W'(1));
        end
    end

    // Count, flag and wait-time registers, all updated together
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcount   <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_wtime    <= '0;
            r_drop_err <= 1'b0;
        end else begin
            r_pcount   <= w_cnt_nxt;
            r_full     <= (w_cnt_nxt == MAX_C);
            r_empty    <= (w_cnt_nxt == '0);
            r_wtime    <= w_wtime_nxt;
            r_drop_err <= w_drop_nxt;
        end
    end

    assign Pcount   = r_pcount;
    assign full     = r_full;
    assign empty    = r_empty;
    assign wtime    = r_wtime;
    assign drop_err = r_drop_err;

    // Capacity must stay a single BCD digit and the wait estimate must fit
    if (MAX_COUNT < 1 || MAX_COUNT > 9) begin : g_bad_max_count
        $error("queue_counter: MAX_COUNT must be in 1..9");
    end
    if (SERVICE_T < 0 || SERVICE_T * (MAX_COUNT - 1) > 255) begin : g_bad_service_t
        $error("queue_counter: SERVICE_T*(MAX_COUNT-1) must fit in 8 bits");
    end

endmodule
